// File: rtl/uart_disp_cmd_ctrl.sv
// UART receive-FIFO sequencer: pops one byte at a time, decodes ASCII hex-digit
// commands into a pending buffer and commits complete entries to the display register.
module uart_disp_cmd_ctrl #(
  parameter int NDIG = 4,
  parameter int ERRW = 8,
  localparam int CW  = $clog2(NDIG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_empty,
  input  logic [7:0]          rx_data,
  output logic                rd_uart,
  output logic [4*NDIG-1:0]   disp_val,
  output logic [NDIG-1:0]     disp_en,
  output logic                disp_upd,
  output logic [CW-1:0]       pend_cnt,
  output logic [ERRW-1:0]     err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [CW-1:0]   CNT_MAX = CW'(NDIG);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [ERRW-1:0] ERR_ONE = ERRW'(1);
  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  state_t              state_r, state_s;
  logic [7:0]          byte_r;
  logic [4*NDIG-1:0]   pend_buf_r, pend_buf_s;
  logic [NDIG-1:0]     pend_mask_r, pend_mask_s;
  logic [CW-1:0]       pend_cnt_r, pend_cnt_s;
  logic [4*NDIG-1:0]   disp_val_r, disp_val_s;
  logic [NDIG-1:0]     disp_en_r, disp_en_s;
  logic                disp_upd_r, disp_upd_s;
  logic [ERRW-1:0]     err_cnt_r, err_cnt_s;
  logic                is_dig_s, is_upper_s, is_lower_s, is_hex_s, is_eol_s, is_esc_s;

  // ASCII hex digit to nibble using 8-bit subtraction; non-hex bytes map to zero
  function automatic logic [3:0] hex_nib(input logic [7:0] b);
    logic [7:0] d;
    if (b >= 8'h30 && b <= 8'h39) begin
      d = b - 8'h30;
    end else if (b >= 8'h41 && b <= 8'h46) begin
      d = b - 8'h37;
    end else if (b >= 8'h61 && b <= 8'h66) begin
      d = b - 8'h57;
    end else begin
      d = 8'h00;
    end
    return d[3:0];
  endfunction

  // Byte classification of the captured byte
  always_comb begin
    is_dig_s   = (byte_r >= 8'h30) && (byte_r <= 8'h39);
    is_upper_s = (byte_r >= 8'h41) && (byte_r <= 8'h46);
    is_lower_s = (byte_r >= 8'h61) && (byte_r <= 8'h66);
    is_hex_s   = is_dig_s || is_upper_s || is_lower_s;
    is_eol_s   = (byte_r == 8'h0D) || (byte_r == 8'h0A);
    is_esc_s   = (byte_r == 8'h1B);
  end

  // Next-state logic; rx_empty only matters in IDLE, so pops are always 3 cycles apart
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_empty) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP:     state_s = DECODE;
      DECODE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Pending-buffer, display and error-counter updates applied in DECODE
  always_comb begin
    pend_buf_s  = pend_buf_r;
    pend_mask_s = pend_mask_r;
    pend_cnt_s  = pend_cnt_r;
    disp_val_s  = disp_val_r;
    disp_en_s   = disp_en_r;
    disp_upd_s  = 1'b0;
    err_cnt_s   = err_cnt_r;
    if (state_r == DECODE) begin
      if (is_hex_s) begin
        pend_buf_s  = (pend_buf_r << 4) | {{(4*NDIG-4){1'b0}}, hex_nib(byte_r)};
        pend_mask_s = (pend_mask_r << 1) | {{(NDIG-1){1'b0}}, 1'b1};
        if (pend_cnt_r == CNT_MAX) begin
          pend_cnt_s = pend_cnt_r;
        end else begin
          pend_cnt_s = pend_cnt_r + CNT_ONE;
        end
      end else if (is_eol_s) begin
        // An empty entry commits nothing, which folds a CR LF pair into one update
        if (pend_cnt_r != {CW{1'b0}}) begin
          disp_val_s  = pend_buf_r;
          disp_en_s   = pend_mask_r;
          disp_upd_s  = 1'b1;
          pend_buf_s  = {(4*NDIG){1'b0}};
          pend_mask_s = {NDIG{1'b0}};
          pend_cnt_s  = {CW{1'b0}};
        end else begin
          disp_upd_s  = 1'b0;
        end
      end else if (is_esc_s) begin
        pend_buf_s  = {(4*NDIG){1'b0}};
        pend_mask_s = {NDIG{1'b0}};
        pend_cnt_s  = {CW{1'b0}};
      end else begin
        if (err_cnt_r != ERR_MAX) begin
          err_cnt_s = err_cnt_r + ERR_ONE;
        end else begin
          err_cnt_s = err_cnt_r;
        end
      end
    end else begin
      disp_upd_s = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      byte_r      <= 8'h00;
      pend_buf_r  <= {(4*NDIG){1'b0}};
      pend_mask_r <= {NDIG{1'b0}};
      pend_cnt_r  <= {CW{1'b0}};
      disp_val_r  <= {(4*NDIG){1'b0}};
      disp_en_r   <= {NDIG{1'b0}};
      disp_upd_r  <= 1'b0;
      err_cnt_r   <= {ERRW{1'b0}};
    end else begin
      state_r     <= state_s;
      if (state_r == POP) begin
        byte_r <= rx_data;
      end else begin
        byte_r <= byte_r;
      end
      pend_buf_r  <= pend_buf_s;
      pend_mask_r <= pend_mask_s;
      pend_cnt_r  <= pend_cnt_s;
      disp_val_r  <= disp_val_s;
      disp_en_r   <= disp_en_s;
      disp_upd_r  <= disp_upd_s;
      err_cnt_r   <= err_cnt_s;
    end
  end

  assign rd_uart  = (state_r == POP);
  assign disp_val = disp_val_r;
  assign disp_en  = disp_en_r;
  assign disp_upd = disp_upd_r;
  assign pend_cnt = pend_cnt_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_uart_disp_cmd_ctrl.sv
// Directed bench for uart_disp_cmd_ctrl: a show-ahead FIFO model feeds byte strings
// and hand-computed display/counter values are compared after each sequence.
module tb_uart_disp_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rd_uart;
  logic [15:0] disp_val;
  logic [3:0]  disp_en;
  logic        disp_upd;
  logic [2:0]  pend_cnt;
  logic [7:0]  err_cnt;

  uart_disp_cmd_ctrl #(.NDIG(4), .ERRW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_empty (rx_empty),
    .rx_data  (rx_data),
    .rd_uart  (rd_uart),
    .disp_val (disp_val),
    .disp_en  (disp_en),
    .disp_upd (disp_upd),
    .pend_cnt (pend_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q[$];
  int  n_chk = 0;
  int  n_bad = 0;
  int  cyc_n = 0;
  int  n_pop, n_upd, n_b2b, n_empty_pop;
  int  last_pop_cyc, upd_cyc;
  int  pop_cyc_q[$];
  logic pop_req = 1'b0;
  logic prev_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd_rx();
    if (q.size() > 0) begin
      rx_empty = 1'b0;
      rx_data  = q[0];
    end else begin
      rx_empty = 1'b1;
      rx_data  = 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    upd_rx();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push(s[i]);
  endtask

  task automatic clr_stats();
    n_pop = 0; n_upd = 0; n_b2b = 0; n_empty_pop = 0;
    last_pop_cyc = -1; upd_cyc = -1;
    pop_cyc_q.delete();
  endtask

  // One clock: pop the model FIFO if the DUT strobed last cycle, then sample outputs
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (pop_req && q.size() > 0) void'(q.pop_front());
    upd_rx();
    pop_req = rd_uart;
    if (rd_uart) begin
      n_pop++;
      last_pop_cyc = cyc_n;
      pop_cyc_q.push_back(cyc_n);
      if (prev_rd) n_b2b++;
      if (rx_empty) n_empty_pop++;
    end
    prev_rd = rd_uart;
    if (disp_upd) begin
      n_upd++;
      upd_cyc = cyc_n;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      cyc();
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    repeat (4) cyc();
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val",  disp_val, 16'h0000);
    chk("rst_en",   disp_en,  4'h0);
    chk("rst_rd",   rd_uart,  1'b0);
    chk("rst_upd",  disp_upd, 1'b0);
    chk("rst_pend", pend_cnt, 3'd0);
    chk("rst_err",  err_cnt,  8'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // 1: "12" CR
    clr_stats();
    push_str("12"); push(8'h0D);
    drain(40);
    chk("t1_pops",   n_pop, 3);
    chk("t1_b2b",    n_b2b, 0);
    chk("t1_val",    disp_val, 16'h0012);
    chk("t1_en",     disp_en, 4'b0011);
    chk("t1_upd",    n_upd, 1);
    chk("t1_updlat", upd_cyc - last_pop_cyc, 2);
    chk("t1_pend",   pend_cnt, 3'd0);

    // 2: "abcde" then LF; 'a' falls off the top
    clr_stats();
    push_str("abcde");
    drain(60);
    chk("t2_pend_sat", pend_cnt, 3'd4);
    chk("t2_hold_val", disp_val, 16'h0012);
    push(8'h0A);
    drain(20);
    chk("t2_val", disp_val, 16'hBCDE);
    chk("t2_en",  disp_en, 4'b1111);
    chk("t2_err", err_cnt, 8'd0);
    chk("t2_upd", n_upd, 1);
    chk("t2_pend", pend_cnt, 3'd0);

    // 3: "7" ESC CR, then "9" CR LF
    clr_stats();
    push(8'h37); push(8'h1B); push(8'h0D);
    drain(40);
    chk("t3_upd0", n_upd, 0);
    chk("t3_val0", disp_val, 16'hBCDE);
    chk("t3_pend", pend_cnt, 3'd0);
    clr_stats();
    push(8'h39); push(8'h0D); push(8'h0A);
    drain(40);
    chk("t3_val", disp_val, 16'h0009);
    chk("t3_en",  disp_en, 4'b0001);
    chk("t3_upd", n_upd, 1);

    // 4: unrecognised bytes, then error saturation
    clr_stats();
    push(8'h47); push(8'h20); push(8'hFF); push(8'h35); push(8'h0D);
    drain(60);
    chk("t4_err", err_cnt, 8'd3);
    chk("t4_val", disp_val, 16'h0005);
    for (int i = 0; i < 300; i++) push(8'h7A);
    drain(1000);
    chk("t4_err_sat", err_cnt, 8'd255);
    chk("t4_val_hold", disp_val, 16'h0005);
    chk("t4_empty_pop", n_empty_pop, 0);

    // 5: four bytes queued at once, rx_empty low throughout
    clr_stats();
    push(8'h33); push(8'h34); push(8'h0D); push(8'h35);
    drain(40);
    chk("t5_pops", pop_cyc_q.size(), 4);
    if (pop_cyc_q.size() == 4) begin
      chk("t5_gap1", pop_cyc_q[1] - pop_cyc_q[0], 3);
      chk("t5_gap2", pop_cyc_q[2] - pop_cyc_q[1], 3);
      chk("t5_gap3", pop_cyc_q[3] - pop_cyc_q[2], 3);
    end
    chk("t5_val",  disp_val, 16'h0034);
    chk("t5_en",   disp_en, 4'b0011);
    chk("t5_pend", pend_cnt, 3'd1);

    // 6: reset while decoding a CR with two digits pending
    clr_stats();
    push(8'h1B); push(8'h36); push(8'h37);
    drain(40);
    chk("t6_pend2", pend_cnt, 3'd2);
    push(8'h0D);
    begin
      int n = 0;
      pop_req = 1'b0;
      while (!pop_req && n < 20) begin
        cyc();
        n++;
      end
      chk("t6_pop_seen", pop_req, 1'b1);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_val",  disp_val, 16'h0000);
    chk("t6_rst_en",   disp_en,  4'h0);
    chk("t6_rst_rd",   rd_uart,  1'b0);
    chk("t6_rst_pend", pend_cnt, 3'd0);
    chk("t6_rst_err",  err_cnt,  8'd0);
    pop_req = 1'b0;
    prev_rd = 1'b0;
    clr_stats();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("t6_idle_pops", n_pop, 0);
    chk("t6_no_upd",    n_upd, 0);
    chk("t6_val_after", disp_val, 16'h0000);
    push(8'h38); push(8'h0D);
    drain(30);
    chk("t6_val_new", disp_val, 16'h0008);
    chk("t6_en_new",  disp_en, 4'b0001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
